// File: rtl/spi_target_port.sv
`timescale 1ns/1ps
// spi_target_port
//   SPI mode-0 target port. The SPI pins are oversampled in the wb_clk_i
//   domain: MOSI is deserialised into parallel words, and a word supplied by
//   the host through a valid/ready holding register is serialised onto MISO.
//
//   Build option: define SPI_TARGET_LSB_FIRST_EN for LSB-first shifting on
//   both lines (default is MSB-first).
//
// Ports
//   wb_clk_i, wb_rst_i   system clock, asynchronous active-high reset
//   sck_i, mosi_i        SPI clock (idle low) and master-out data
//   ss_n_i               active-low target select
//   miso_o, miso_oe_o    target-out data and its drive enable
//   tx_data_i/valid_i    next word to send; tx_ready_o = holding reg empty
//   rx_data_o, rx_valid_o  last received word and its one-cycle strobe
//   busy_o               selected and a word in progress
//   tx_underrun_o        one-cycle strobe: word started with nothing to send
module spi_target_port #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  sck_i,
  input  logic                  mosi_i,
  input  logic                  ss_n_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  tx_underrun_o
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    NEXT
  } state_t;

  state_t state;

  // Input synchronisers. ss_n resets high so no select edge appears at reset.
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic sck_s, mosi_s, ss_s;
  logic sck_q, ss_q, mosi_q;
  logic sck_rise, sck_fall, ss_fall, ss_rise;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sck_q     <= 1'b0;
      ss_q      <= 1'b1;
      mosi_q    <= 1'b0;
      sck_rise  <= 1'b0;
      sck_fall  <= 1'b0;
      ss_fall   <= 1'b0;
      ss_rise   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_i};
      sck_q     <= sck_s;
      ss_q      <= ss_s;
      // MOSI is delayed alongside the edge strobes so it is sampled aligned
      mosi_q    <= mosi_s;
      sck_rise  <= sck_s & ~sck_q;
      sck_fall  <= ~sck_s & sck_q;
      ss_fall   <= ~ss_s & ss_q;
      ss_rise   <= ss_s & ~ss_q;
    end
  end

  // TX holding register
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_full;
  logic                  do_load;
  logic                  tx_xfer;
  logic [DATA_WIDTH-1:0] load_word;

  assign tx_ready_o = ~hold_full;
  assign tx_xfer    = tx_valid_i & ~hold_full;
  assign do_load    = (state == LOAD) && !ss_rise;

  // An empty register with a write in the same cycle bypasses straight in.
  always_comb begin
    load_word = '1;
    if (hold_full) begin
      load_word = hold_data;
    end else if (tx_valid_i) begin
      load_word = tx_data_i;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (do_load && hold_full) begin
      hold_full <= 1'b0;
    end else if (tx_xfer && !do_load) begin
      hold_data <= tx_data_i;
      hold_full <= 1'b1;
    end
  end

  // Shifters. TX rotates rather than zero-fills; only the output bit matters.
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] tx_next;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-2:0] rx_keep;
  logic                  load_bit;
  logic                  next_bit;

`ifdef SPI_TARGET_LSB_FIRST_EN
  assign tx_next  = {tx_shift[0], tx_shift[DATA_WIDTH-1:1]};
  assign load_bit = load_word[0];
  assign next_bit = tx_next[0];
  assign rx_next  = {mosi_q, rx_shift};
  assign rx_keep  = rx_next[DATA_WIDTH-1:1];
`else
  assign tx_next  = {tx_shift[DATA_WIDTH-2:0], tx_shift[DATA_WIDTH-1]};
  assign load_bit = load_word[DATA_WIDTH-1];
  assign next_bit = tx_next[DATA_WIDTH-1];
  assign rx_next  = {rx_shift, mosi_q};
  assign rx_keep  = rx_next[DATA_WIDTH-2:0];
`endif

  logic [CNT_W-1:0] bit_cnt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      tx_shift      <= '0;
      rx_shift      <= '0;
      bit_cnt       <= '0;
      miso_o        <= 1'b0;
      miso_oe_o     <= 1'b0;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
    end else begin
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      if (ss_rise) begin
        state     <= IDLE;
        miso_oe_o <= 1'b0;
        miso_o    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ss_fall) begin
              state <= LOAD;
            end
          end
          LOAD: begin
            tx_shift  <= load_word;
            miso_o    <= load_bit;
            miso_oe_o <= 1'b1;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            state     <= SHIFT;
            if (!hold_full && !tx_valid_i) begin
              tx_underrun_o <= 1'b1;
            end
          end
          SHIFT: begin
            if (sck_rise) begin
              rx_shift <= rx_keep;
              bit_cnt  <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                rx_data_o  <= rx_next;
                rx_valid_o <= 1'b1;
                state      <= NEXT;
              end
            end else if (sck_fall) begin
              tx_shift <= tx_next;
              miso_o   <= next_bit;
            end
          end
          NEXT: begin
            if (sck_fall) begin
              state <= LOAD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_spi_target_port.sv
`timescale 1ns/1ps
module tb_spi_target_port;

  localparam int unsigned HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       ss_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       miso_o, miso_oe_o, tx_ready_o, rx_valid_o, busy_o, tx_underrun_o;
  logic [7:0] rx_data_o;

  spi_target_port #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .sck_i         (sck),
    .mosi_i        (mosi),
    .ss_n_i        (ss_n),
    .miso_o        (miso_o),
    .miso_oe_o     (miso_oe_o),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready_o),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .busy_o        (busy_o),
    .tx_underrun_o (tx_underrun_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  int unsigned rx_cnt = 0;
  int unsigned uf_cnt = 0;
  logic [7:0]  rx_log [16];

  always @(posedge clk) begin
    if (rx_valid_o) begin
      rx_log[rx_cnt[3:0]] <= rx_data_o;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_underrun_o) uf_cnt <= uf_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tx_write(input logic [7:0] d);
    int unsigned w = 0;
    while (tx_ready_o !== 1'b1 && w < 100) begin
      step(1);
      w++;
    end
    check("tx_ready_wait", tx_ready_o, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
  endtask

  task automatic select_target();
    ss_n = 1'b0;
    step(HALF);
  endtask

  // Final fall of a selection coincides with ss_n rise; MISO must be off
  // within SYNC_STAGES+2 cycles.
  task automatic deselect_target(input string tag);
    sck  = 1'b0;
    ss_n = 1'b1;
    step(4);
    check({tag, "_oe_off"}, miso_oe_o, 0);
    check({tag, "_busy_off"}, busy_o, 0);
    step(HALF);
  endtask

  // Master mode 0: drive MOSI while sck low, sample MISO just before rise.
  // With last_word set the final bit leaves sck high for deselect_target.
  task automatic spi_bits(input logic [7:0] out_b, input int unsigned nbits,
                          input int unsigned wr_at, input logic [7:0] wr_data,
                          input logic last_word,
                          output logic [7:0] in_b, output logic first);
    in_b  = 8'h00;
    first = 1'b0;
    for (int unsigned i = 0; i < nbits; i++) begin
`ifdef SPI_TARGET_LSB_FIRST_EN
      mosi = out_b[i];
`else
      mosi = out_b[7-i];
`endif
      step(HALF);
      if (i == 0) first = miso_o;
`ifdef SPI_TARGET_LSB_FIRST_EN
      in_b = {miso_o, in_b[7:1]};
`else
      in_b = {in_b[6:0], miso_o};
`endif
      sck = 1'b1;
      if (i == wr_at) begin
        check("hold_ready", tx_ready_o, 1);
        tx_data  = wr_data;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        step(HALF - 1);
      end else begin
        step(HALF);
      end
      if (!(last_word && i == nbits - 1)) sck = 1'b0;
    end
  endtask

  logic [7:0] got, got2;
  logic       fb;

  initial begin
    // Reset
    step(3);
    rst = 1'b0;
    step(2);
    check("rst_miso", miso_o, 0);
    check("rst_oe", miso_oe_o, 0);
    check("rst_ready", tx_ready_o, 1);
    check("rst_rxdata", rx_data_o, 0);
    check("rst_rxvalid", rx_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_underrun", tx_underrun_o, 0);

    // Single word: TX 0xA5, master sends 0x3C
    tx_write(8'hA5);
    check("ready_drop", tx_ready_o, 0);
    select_target();
    check("t1_busy", busy_o, 1);
    check("t1_oe", miso_oe_o, 1);
    check("t1_ready_after_load", tx_ready_o, 1);
    spi_bits(8'h3C, 8, 99, 8'h00, 1'b1, got, fb);
    check("t1_first_bit", fb, 1);
    check("t1_miso_word", got, 8'hA5);
    check("t1_rx_data", rx_data_o, 8'h3C);
    check("t1_rx_log", rx_log[0], 8'h3C);
    deselect_target("t1");
    check("t1_miso_low", miso_o, 0);
    check("t1_rx_count", rx_cnt, 1);
    check("t1_no_underrun", uf_cnt, 0);

    // Back-to-back: 0x11 preloaded, 0x22 written during the first word
    tx_write(8'h11);
    select_target();
    spi_bits(8'hF0, 8, 2, 8'h22, 1'b0, got, fb);
    spi_bits(8'h0F, 8, 99, 8'h00, 1'b1, got2, fb);
    deselect_target("b2b");
    check("b2b_miso0", got, 8'h11);
    check("b2b_miso1", got2, 8'h22);
    check("b2b_rx_count", rx_cnt, 3);
    check("b2b_rx0", rx_log[1], 8'hF0);
    check("b2b_rx1", rx_log[2], 8'h0F);
    check("b2b_no_underrun", uf_cnt, 0);
    check("b2b_ready", tx_ready_o, 1);

    // Underrun: nothing written
    select_target();
    spi_bits(8'h5A, 8, 99, 8'h00, 1'b1, got, fb);
    deselect_target("ur");
    check("ur_miso_ones", got, 8'hFF);
    check("ur_pulse_count", uf_cnt, 1);
    check("ur_rx_count", rx_cnt, 4);
    check("ur_rx", rx_log[3], 8'h5A);

    // Abort after 5 sck edges; a write made during it must survive
    select_target();
    check("ab_underrun", uf_cnt, 2);
    spi_bits(8'hE7, 3, 1, 8'h96, 1'b1, got, fb);
    deselect_target("ab");
    check("ab_no_rx", rx_cnt, 4);
    check("ab_hold_kept", tx_ready_o, 0);
    select_target();
    spi_bits(8'hC3, 8, 99, 8'h00, 1'b1, got, fb);
    deselect_target("ab2");
    check("ab2_miso", got, 8'h96);
    check("ab2_rx", rx_data_o, 8'hC3);
    check("ab2_rx_count", rx_cnt, 5);
    check("ab2_underrun", uf_cnt, 2);

    // Reset mid-word discards the word and the holding register
    tx_write(8'h77);
    select_target();
    spi_bits(8'hAA, 4, 99, 8'h00, 1'b1, got, fb);
    tx_write(8'h3E);
    rst = 1'b1;
    #2;
    check("mr_ready", tx_ready_o, 1);
    check("mr_busy", busy_o, 0);
    check("mr_oe", miso_oe_o, 0);
    check("mr_miso", miso_o, 0);
    check("mr_rxdata", rx_data_o, 0);
    check("mr_rxvalid", rx_valid_o, 0);
    check("mr_underrun", tx_underrun_o, 0);
    sck  = 1'b0;
    ss_n = 1'b1;
    step(3);
    rst = 1'b0;
    step(3);
    check("mr_rx_count", rx_cnt, 5);

    // Bit order: TX 0x01, master sends 0x80
    tx_write(8'h01);
    select_target();
    spi_bits(8'h80, 8, 99, 8'h00, 1'b1, got, fb);
`ifdef SPI_TARGET_LSB_FIRST_EN
    check("bo_first_bit", fb, 1);
`else
    check("bo_first_bit", fb, 0);
`endif
    check("bo_miso", got, 8'h01);
    check("bo_rx", rx_data_o, 8'h80);
    deselect_target("bo");
    check("bo_rx_count", rx_cnt, 6);
    check("bo_underrun", uf_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_target_port.md
# spi_target_port

SPI mode-0 target (slave) port: the far end of the SPI link driven by the team's I2C-to-SPI bridge master (sck/mosi out, miso in). It oversamples the SPI pins in the `wb_clk_i` domain, deserialises MOSI into parallel words and serialises a host-supplied word onto MISO. The parallel side uses a valid/ready transmit handshake and a receive strobe. It serves as the loopback/bring-up target for the bridge and as a reusable SPI peripheral front end.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per SPI word.
- `SYNC_STAGES`, 2: synchroniser depth on `sck_i`, `mosi_i` and `ss_n_i`; minimum 2.

Ports:
- `wb_clk_i` in 1: single system clock; all logic is on its rising edge.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `sck_i` in 1: SPI clock from the master, idle low.
- `mosi_i` in 1: master-out data.
- `ss_n_i` in 1: active-low target select.
- `miso_o` out 1: target-out data.
- `miso_oe_o` out 1: MISO drive enable; high only while selected.
- `tx_data_i` in DATA_WIDTH: next word to transmit.
- `tx_valid_i` in 1: `tx_data_i` is valid.
- `tx_ready_o` out 1: TX holding register is empty.
- `rx_data_o` out DATA_WIDTH: last complete received word.
- `rx_valid_o` out 1: one-cycle strobe, `rx_data_o` updated.
- `busy_o` out 1: selected, and a word is in progress.
- `tx_underrun_o` out 1: one-cycle strobe; a word was started with an empty holding register.

## Operation
- Reset values:
  - `miso_o`=0, `miso_oe_o`=0, `tx_ready_o`=1, `rx_data_o`=0, `rx_valid_o`=0, `busy_o`=0, `tx_underrun_o`=0.
  - Shift registers, bit counter and holding register are cleared; FSM=IDLE.
- Input conditioning: each SPI input passes through `SYNC_STAGES` flops. One further flop provides edge detection: sck rise, sck fall, ss_n fall, ss_n rise.
- TX holding register:
  - A transfer occurs when `tx_valid_i && tx_ready_o`.
  - `tx_ready_o` drops the cycle after a transfer and rises the cycle after the register is loaded into the TX shifter.
- FSM:
  - IDLE: on synchronised ss_n fall → LOAD.
  - LOAD (1 cycle):
    - Loads the TX shifter from the holding register, or from an all-ones word if the register is empty.
    - An empty-register load pulses `tx_underrun_o`.
    - Bit counter is set to 0; `miso_oe_o`=1; `miso_o` = first bit; → SHIFT.
  - SHIFT, on sck rise:
    - Sample synchronised MOSI into the RX shifter; increment the bit counter.
    - When the counter reaches DATA_WIDTH: update `rx_data_o`, pulse `rx_valid_o`, → NEXT.
  - SHIFT, on sck fall: advance the TX shifter and drive the next bit on `miso_o`.
  - NEXT: on sck fall → LOAD, for a back-to-back word.
  - Any state, on synchronised ss_n rise → IDLE:
    - `miso_oe_o`=0, `miso_o`=0.
    - Partial RX bits are discarded with no `rx_valid_o`.
    - The partially sent TX word is lost.
    - An unconsumed holding register is kept.
- `busy_o`=1 in LOAD, SHIFT and NEXT.
- Simultaneous TX write and LOAD with an empty register: the write is bypassed straight into the shifter. There is no underrun, and `tx_ready_o` stays 1.
- Edges of sck while ss_n is high are ignored.
- Bit counter width is clog2(DATA_WIDTH+1). The counter wraps only via LOAD.

## Timing
- Pin-to-internal latency is `SYNC_STAGES`+1 cycles for every SPI input event.
- `rx_valid_o` asserts `SYNC_STAGES`+2 cycles after the last sck rising edge at the pin.
- `miso_o` updates `SYNC_STAGES`+2 cycles after an sck falling edge at the pin.
- First MISO bit is valid `SYNC_STAGES`+3 cycles after the ss_n falling edge at the pin.
- Master constraints:
  - Each sck half period ≥ `SYNC_STAGES`+4 `wb_clk_i` periods.
  - ss_n fall to first sck rise ≥ `SYNC_STAGES`+5 periods.
  - ss_n high time ≥ 2 periods.
- Behaviour outside these constraints is undefined, but it never wedges the FSM: ss_n rise always returns it to IDLE.
- Asserting `wb_rst_i` mid-word forces the reset values immediately, asynchronously. The current word and the holding register are discarded.

## Configuration
- `SPI_TARGET_LSB_FIRST_EN`:
  - Defined: both shifters are LSB-first. `miso_o` starts with bit 0, and MOSI bits fill from bit 0 upward.
  - Undefined (default): MSB-first on both lines.
- Handshakes, timing and underrun pattern (all ones) are identical in both builds.

## Test plan
- Reset: assert `wb_rst_i` mid-word → every output shows its reset value next sample, `tx_ready_o`=1.
- Single word, MSB-first, DATA_WIDTH=8:
  - Stimulus: preload TX 0xA5; master sends 0x3C with sck half period of 8 clks.
  - Response: MISO bits 1,0,1,0,0,1,0,1; `rx_data_o`=0x3C with exactly one `rx_valid_o` pulse; `tx_ready_o` high again after LOAD.
- Back-to-back:
  - Stimulus: TX 0x11 then 0x22 written during the first word; master sends 0xF0, 0x0F in one select.
  - Response: MISO carries 0x11 then 0x22; two `rx_valid_o` pulses with 0xF0 then 0x0F.
- Underrun: no TX write, master clocks 8 bits → MISO all 1s, one `tx_underrun_o` pulse, `rx_valid_o` still pulses.
- Abort: ss_n rises after 5 sck edges → no `rx_valid_o`, `miso_oe_o`=0 within `SYNC_STAGES`+2 cycles, next select transfers a fresh full word correctly.
- LSB-first build: `SPI_TARGET_LSB_FIRST_EN` defined, TX 0x01 → MISO first bit 1 then seven 0s; master LSB-first 0x80 → `rx_data_o`=0x80.
